// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  // Width needed to count up to the largest of the four cycle parameters.
  function automatic int clog2_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, async active-low reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL RST, filters LOCK, retries on timeout and
// releases downstream domain resets in staggered order once lock is stable.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_DOMAINS     = 3,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 250000,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic [N_DOMAINS-1:0]               domain_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [2:0]                         state_dbg
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = clog2_max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER * N_DOMAINS);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [RW-1:0]         retry_nxt, retry_inc;
  logic [N_DOMAINS-1:0]  mask, mask_nxt;
  logic                  lock_s, enter, counting;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  assign retry_inc = (retry_count == RW'(MAX_RETRIES)) ? retry_count : retry_count + RW'(1);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    mask_nxt  = mask;
    case (state)
      RESET_PLL: if (cnt == CW'(RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) state_nxt = STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RW'(MAX_RETRIES)) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1)) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!lock_s) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RW'(MAX_RETRIES)) ? FAULT : RESET_PLL;
        end else begin
          for (int k = 0; k < N_DOMAINS; k++)
            if (cnt == CW'(STAGGER * (k + 1) - 1)) mask_nxt[k] = 1'b1;
          if (cnt == CW'(STAGGER * N_DOMAINS - 1)) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RW'(MAX_RETRIES)) ? FAULT : RESET_PLL;
        end
      end
      FAULT:   ;
      default: state_nxt = RESET_PLL;
    endcase
    // Domains may only be out of reset while releasing or running.
    if (state_nxt != RELEASE && state_nxt != RUN) mask_nxt = '0;
    if (state_nxt == RUN) retry_nxt = '0;
    if (restart) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
      mask_nxt  = '0;
    end
  end

  assign enter    = restart || (state_nxt != state);
  assign counting = (state == RESET_PLL) || (state == WAIT_LOCK) ||
                    (state == STABLE)    || (state == RELEASE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      mask        <= '0;
      pll_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      if (enter)         cnt <= '0;
      else if (counting) cnt <= cnt + CW'(1);
      retry_count <= retry_nxt;
      mask        <= mask_nxt;
      pll_rst     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      ready       <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

  assign domain_rst_n = mask;
  assign state_dbg    = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed + randomized bench for pll_lock_supervisor against a timing model.
module tb_pll_lock_supervisor;

  localparam int ND = 3, RC = 4, TO = 50, SC = 10, SG = 3, MR = 2;
  localparam int ST_RST = 0, ST_WAIT = 1, ST_STB = 2, ST_REL = 3, ST_RUN = 4, ST_FLT = 5;

  logic          clock = 1'b0;
  logic          reset_n, pll_locked, restart;
  logic          pll_rst, ready, fault;
  logic [ND-1:0] domain_rst_n;
  logic [1:0]    retry_count;
  logic [2:0]    state_dbg;

  int errors = 0, checks = 0;

  // Model: phase, edges elapsed in phase, retries, two-stage lock history.
  int m_st, m_n, m_retry;
  bit h1, h2;

  pll_lock_supervisor #(
    .N_DOMAINS(ND), .RST_CYCLES(RC), .LOCK_TIMEOUT(TO),
    .STABLE_CYCLES(SC), .STAGGER(SG), .MAX_RETRIES(MR)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = ST_RST; m_n = 0; m_retry = 0; h1 = 0; h2 = 0;
  endtask

  task automatic m_go(input int s);
    m_st = s; m_n = 0;
  endtask

  task automatic m_fail();
    m_retry = (m_retry < MR) ? m_retry + 1 : MR;
    m_go((m_retry == MR) ? ST_FLT : ST_RST);
  endtask

  task automatic m_edge();
    bit ls;
    int j;
    ls = h2; h2 = h1; h1 = pll_locked; j = m_n + 1;
    if (restart) begin
      m_retry = 0;
      m_go(ST_RST);
      return;
    end
    case (m_st)
      ST_RST:  if (j == RC) m_go(ST_WAIT); else m_n = j;
      ST_WAIT: if (ls) m_go(ST_STB); else if (j == TO) m_fail(); else m_n = j;
      ST_STB:  if (!ls) m_go(ST_WAIT); else if (j == SC) m_go(ST_REL); else m_n = j;
      ST_REL:  if (!ls) m_fail(); else if (j == SG * ND) m_go(ST_RUN); else m_n = j;
      ST_RUN:  if (!ls) m_fail();
      default: ;
    endcase
    if (m_st == ST_RUN) m_retry = 0;
  endtask

  function automatic logic [ND-1:0] exp_dom();
    logic [ND-1:0] d;
    d = '0;
    if (m_st == ST_RUN) d = '1;
    else if (m_st == ST_REL)
      for (int k = 0; k < ND; k++) d[k] = (m_n >= SG * (k + 1));
    return d;
  endfunction

  task automatic check_all();
    chk("pll_rst",      pll_rst,      (m_st == ST_RST || m_st == ST_FLT));
    chk("ready",        ready,        (m_st == ST_RUN));
    chk("fault",        fault,        (m_st == ST_FLT));
    chk("retry_count",  retry_count,  m_retry);
    chk("state_dbg",    state_dbg,    m_st);
    chk("domain_rst_n", domain_rst_n, exp_dom());
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) m_reset(); else m_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic run_until(input int st, input int max_cycles);
    for (int i = 0; i < max_cycles && m_st != st; i++) tick();
    chk("reach_state", state_dbg, st);
  endtask

  initial begin
    reset_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    m_reset();
    repeat (3) tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_dom", domain_rst_n, 0);
    reset_n = 1'b1;

    // Nominal: lock appears around cycle 20, full release sequence.
    repeat (19) tick();
    pll_locked = 1'b1;
    run_until(ST_RUN, 100);
    chk("nom_dom", domain_rst_n, 3'b111);
    chk("nom_ready", ready, 1);

    // Lock loss in RUN: domains back in reset 3 cycles after the pin.
    repeat (5) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("loss_dom", domain_rst_n, 0);
    chk("loss_ready", ready, 0);
    chk("loss_retry", retry_count, 1);
    pll_locked = 1'b1;
    run_until(ST_RUN, 100);
    chk("relock_retry", retry_count, 0);

    // One-cycle glitch while in STABLE restarts the stable window.
    restart = 1'b1; tick(); restart = 1'b0;
    run_until(ST_STB, 20);
    while (m_st == ST_STB && m_n < 4) tick();
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    run_until(ST_WAIT, 5);
    chk("glitch_retry", retry_count, 0);
    run_until(ST_STB, 10);
    run_until(ST_RUN, 40);

    // Repeated timeouts end in FAULT, which holds.
    pll_locked = 1'b0;
    run_until(ST_FLT, 300);
    chk("flt_fault", fault, 1);
    chk("flt_retry", retry_count, 2);
    repeat (20) tick();
    chk("flt_hold", state_dbg, ST_FLT);
    chk("flt_pll_rst", pll_rst, 1);

    // Restart out of FAULT.
    restart = 1'b1; tick(); restart = 1'b0;
    chk("rs_flt_state", state_dbg, ST_RST);
    chk("rs_flt_fault", fault, 0);
    chk("rs_flt_retry", retry_count, 0);

    // Restart coincident with lock loss seen during RELEASE.
    pll_locked = 1'b1;
    run_until(ST_REL, 100);
    pll_locked = 1'b0;
    tick(); tick();
    restart = 1'b1; tick(); restart = 1'b0;
    chk("rs_rel_state", state_dbg, ST_RST);
    chk("rs_rel_retry", retry_count, 0);
    chk("rs_rel_dom", domain_rst_n, 0);

    // Asynchronous reset mid-RELEASE.
    pll_locked = 1'b1;
    run_until(ST_REL, 100);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_dom", domain_rst_n, 0);
    chk("arst_state", state_dbg, ST_RST);
    chk("arst_ready", ready, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    run_until(ST_RUN, 100);

    // Randomized lock toggling with occasional restarts.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) pll_locked = ~pll_locked;
      restart = ($urandom_range(0, 599) == 0) || (m_st == ST_FLT && $urandom_range(0, 19) == 0);
      tick();
    end
    restart = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
